// File: rtl/ret_shadow_stack.sv
// Shadow return-address stack beside the branch unit: key-encoded push on call, pop/compare on return.
// Latency: compare result (mismatch_o/crash_o) registered one cycle after ret_valid_i; depth_o next cycle.
// Backpressure: none; every resolved call/return is accepted, oldest entry discarded when full.
//
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   mode_i          0 off, 1 detect (report only), 2/3 enforce (sticky crash)
//   key_i           XOR key for stored entries, held stable while entries are valid
//   flush_i         drops all entries and clears crash/overflow; err_count_o kept
//   call_valid_i    resolved call, call_link_i is the link address to shadow
//   ret_valid_i     resolved return, ret_target_i is the resolved target
//   mismatch_o      one-cycle pulse on a failed compare
//   crash_o         sticky crash request (enforce modes)
//   overflow_o      sticky, an entry was discarded since the last flush
//   depth_o         number of valid entries
//   err_count_o     saturating mismatch count
module ret_shadow_stack #(
  parameter int VLEN  = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               mode_i,
  input  logic [VLEN-1:0]          key_i,
  input  logic                     flush_i,
  input  logic                     call_valid_i,
  input  logic [VLEN-1:0]          call_link_i,
  input  logic                     ret_valid_i,
  input  logic [VLEN-1:0]          ret_target_i,
  output logic                     mismatch_o,
  output logic                     crash_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   depth_o,
  output logic [CNT_W-1:0]         err_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  // Entry storage is never cleared; cnt alone decides which slots are live.
  logic [VLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   ptr;
  logic [DW-1:0]   cnt;

  logic            enabled;
  logic            push_act;
  logic            pop_act;
  logic            full;
  logic [VLEN-1:0] top_val;
  logic            miss;
  logic [AW-1:0]   wr_ptr;
  logic            err_sat;

  assign enabled  = (mode_i != 2'd0);
  // Flush wins over everything in the same cycle, including the compare.
  assign push_act = enabled && call_valid_i && !flush_i;
  assign pop_act  = enabled && ret_valid_i && !flush_i && (cnt != '0);
  assign full     = (cnt == DW'(DEPTH));
  assign top_val  = mem[ptr] ^ key_i;
  assign miss     = pop_act && (top_val != ret_target_i);
  assign err_sat  = &err_count_o;

  // With a simultaneous pop, the push refills the slot the pop just vacated.
  assign wr_ptr   = pop_act ? ptr : ptr + AW'(1);

  always_ff @(posedge clk_i) begin
    if (push_act) begin
      mem[wr_ptr] <= call_link_i ^ key_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr         <= '0;
      cnt         <= '0;
      mismatch_o  <= 1'b0;
      crash_o     <= 1'b0;
      overflow_o  <= 1'b0;
      err_count_o <= '0;
    end else begin
      mismatch_o <= miss;

      if (flush_i) begin
        ptr        <= '0;
        cnt        <= '0;
        crash_o    <= 1'b0;
        overflow_o <= 1'b0;
      end else begin
        if (push_act && pop_act) begin
          // Net effect: top replaced in place, depth unchanged, no overflow.
          ptr <= ptr;
          cnt <= cnt;
        end else if (push_act) begin
          ptr <= ptr + AW'(1);
          if (full) begin
            overflow_o <= 1'b1;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end else if (pop_act) begin
          ptr <= ptr - AW'(1);
          cnt <= cnt - DW'(1);
        end

        // mode_i[1] covers both enforce (2) and reserved (3).
        if (miss && mode_i[1]) begin
          crash_o <= 1'b1;
        end
      end

      if (miss && !err_sat) begin
        err_count_o <= err_count_o + CNT_W'(1);
      end
    end
  end

  assign depth_o = cnt;

endmodule

// File: tb/tb_ret_shadow_stack.sv
module tb_ret_shadow_stack;

  localparam int VLEN    = 32;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic                 clk;
  logic                 rst;
  logic [1:0]           mode;
  logic [VLEN-1:0]      key;
  logic                 flush;
  logic                 call_valid;
  logic [VLEN-1:0]      call_link;
  logic                 ret_valid;
  logic [VLEN-1:0]      ret_target;
  logic                 mismatch;
  logic                 crash;
  logic                 overflow;
  logic [$clog2(DEPTH):0] depth;
  logic [CNT_W-1:0]     err_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of plain link addresses, newest at the back.
  logic [VLEN-1:0] q[$];
  bit              m_mis;
  bit              m_crash;
  bit              m_ovf;
  int              m_err;

  ret_shadow_stack #(
    .VLEN (VLEN),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mode_i       (mode),
    .key_i        (key),
    .flush_i      (flush),
    .call_valid_i (call_valid),
    .call_link_i  (call_link),
    .ret_valid_i  (ret_valid),
    .ret_target_i (ret_target),
    .mismatch_o   (mismatch),
    .crash_o      (crash),
    .overflow_o   (overflow),
    .depth_o      (depth),
    .err_count_o  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(m_mis));
    chk({tag, ".crash"},    32'(crash),    32'(m_crash));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".depth"},    32'(depth),    32'(q.size()));
    chk({tag, ".err"},      32'(err_count), 32'(m_err));
  endtask

  task automatic model_reset();
    q.delete();
    m_mis   = 1'b0;
    m_crash = 1'b0;
    m_ovf   = 1'b0;
    m_err   = 0;
  endtask

  // Applies one cycle of stimulus to the model: pop first, then push.
  task automatic model_step(input logic [1:0] md, input bit fl, input bit c,
                            input logic [VLEN-1:0] lk, input bit r,
                            input logic [VLEN-1:0] tg);
    logic [VLEN-1:0] top;
    m_mis = 1'b0;
    if (fl) begin
      q.delete();
      m_crash = 1'b0;
      m_ovf   = 1'b0;
    end else if (md != 2'd0) begin
      if (r && q.size() > 0) begin
        top = q.pop_back();
        if (top != tg) begin
          m_mis = 1'b1;
          if (m_err < ERR_MAX) m_err++;
          if (md >= 2'd2) m_crash = 1'b1;
        end
      end
      if (c) begin
        q.push_back(lk);
        if (q.size() > DEPTH) begin
          void'(q.pop_front());
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic [1:0] md, input bit fl,
                      input bit c, input logic [VLEN-1:0] lk,
                      input bit r, input logic [VLEN-1:0] tg);
    @(negedge clk);
    mode       = md;
    flush      = fl;
    call_valid = c;
    call_link  = lk;
    ret_valid  = r;
    ret_target = tg;
    model_step(md, fl, c, lk, r, tg);
    @(posedge clk);
    #1;
    call_valid = 1'b0;
    ret_valid  = 1'b0;
    flush      = 1'b0;
    check_all(tag);
  endtask

  function automatic logic [VLEN-1:0] addr_a(input int i);
    return 32'h4000_1000 + 32'(4 * i);
  endfunction

  initial begin
    logic [VLEN-1:0] lk;
    logic [VLEN-1:0] tg;
    logic [1:0]      md;
    bit              fl;
    bit              c;
    bit              r;

    rst        = 1'b1;
    mode       = 2'd0;
    key        = 32'h73FA_06C2;
    flush      = 1'b0;
    call_valid = 1'b0;
    call_link  = '0;
    ret_valid  = 1'b0;
    ret_target = '0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic matched call/return in enforce mode.
    step("basic_push", 2'd2, 0, 1, 32'h8000_0104, 0, '0);
    step("basic_ret",  2'd2, 0, 0, '0, 1, 32'h8000_0104);

    // Mismatch in enforce mode: pulse, sticky crash, flush clears crash only.
    step("enf_push", 2'd2, 0, 1, 32'h8000_0104, 0, '0);
    step("enf_ret",  2'd2, 0, 0, '0, 1, 32'h8000_0200);
    step("enf_idle", 2'd2, 0, 0, '0, 0, '0);
    step("enf_flush", 2'd2, 1, 0, '0, 0, '0);

    // Detect mode: pulse and count, no crash.
    step("det_push", 2'd1, 0, 1, 32'h8000_0104, 0, '0);
    step("det_ret",  2'd1, 0, 0, '0, 1, 32'h8000_0200);
    step("det_idle", 2'd1, 0, 0, '0, 0, '0);

    // Overflow and wrap: 10 pushes into 8 entries, 8 matched pops, then underflow.
    for (int i = 0; i < 10; i++) step("ovf_push", 2'd2, 0, 1, addr_a(i), 0, '0);
    for (int i = 9; i >= 2; i--) step("ovf_pop", 2'd2, 0, 0, '0, 1, addr_a(i));
    step("ovf_under", 2'd2, 0, 0, '0, 1, addr_a(1));
    step("ovf_flush", 2'd2, 1, 0, '0, 0, '0);

    // Simultaneous pop+push on a full stack.
    for (int i = 0; i < 8; i++) step("sim_push", 2'd2, 0, 1, addr_a(i), 0, '0);
    step("sim_both", 2'd2, 0, 1, 32'hB000_0010, 1, addr_a(7));
    step("sim_retb", 2'd2, 0, 0, '0, 1, 32'hB000_0010);
    step("sim_ret6", 2'd2, 0, 0, '0, 1, addr_a(6));
    step("sim_flush", 2'd2, 1, 0, '0, 0, '0);

    // Mode 0 ignores calls and returns; stack and flags held.
    step("off_push", 2'd2, 0, 1, 32'h1234_5678, 0, '0);
    step("off_call", 2'd0, 0, 1, 32'hDEAD_0000, 0, '0);
    step("off_ret",  2'd0, 0, 0, '0, 1, 32'hFFFF_0000);
    step("off_match", 2'd2, 0, 0, '0, 1, 32'h1234_5678);

    // Asynchronous reset mid-operation with depth 3 and crash set.
    for (int i = 0; i < 4; i++) step("rst_push", 2'd3, 0, 1, addr_a(20 + i), 0, '0);
    step("rst_bad", 2'd3, 0, 0, '0, 1, 32'h0000_0008);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;
    step("rst_under", 2'd2, 0, 0, '0, 1, addr_a(22));

    // Randomized traffic against the queue model; key only changes while empty.
    for (int n = 0; n < 800; n++) begin
      if (q.size() == 0 && $urandom_range(0, 7) == 0) key = $urandom;
      md = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      fl = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 2) == 0);
      lk = $urandom & 32'hFFFF_FFFE;
      if (q.size() > 0 && $urandom_range(0, 3) != 0) tg = q[$];
      else tg = $urandom & 32'hFFFF_FFFE;
      step("rand", md, fl, c, lk, r, tg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
